gray_ptr_ctl: RTL and testbench
===============================

GRAY_PTR_CTL -- requirements
Module: gray_ptr_ctl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: FIFO address width; depth = 2**ADDR_W; legal range ADDR_W >= 2.
REQ-002 SHALL have parameter MODE, default 0: 0 = write side (flag means full), 1 = read side (flag means empty).
REQ-003 SHALL have parameter SYNC_STAGES, default 2: number of remote-pointer synchroniser flops; legal range >= 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port inc, input, 1 bit: request to advance the local pointer this cycle.
REQ-007 SHALL have port remote_gray, input, ADDR_W+1 bits: opposite-domain Gray pointer, asynchronous to clk.
REQ-008 SHALL have port ptr_gray, output, ADDR_W+1 bits: registered local Gray pointer, sent to the other domain.
REQ-009 SHALL have port addr, output, ADDR_W bits: registered local binary pointer, low ADDR_W bits (RAM address).
REQ-010 SHALL have port flag, output, 1 bit: registered full (MODE 0) or empty (MODE 1).
REQ-011 SHALL have port err, output, 1 bit: sticky; set when inc is asserted while flag = 1.
REQ-012 SHALL have port level, output, ADDR_W+1 bits: registered occupancy; present only with GRAY_PTR_LEVEL_EN.

Function
REQ-013 SHALL use inc_eff = inc AND NOT flag.
REQ-014 SHALL compute bin_next = bin + inc_eff, modulo 2**(ADDR_W+1).
REQ-015 SHALL compute gray_next = (bin_next >> 1) XOR bin_next.
REQ-016 SHALL register bin and ptr_gray from bin_next and gray_next every cycle; addr = bin[ADDR_W-1:0]; pointer latency from inc to ptr_gray is 1 cycle.
REQ-017 SHALL pass remote_gray through SYNC_STAGES flops to form rsync; no logic is placed before the first flop.
REQ-018 MODE 0 SHALL register flag = (gray_next == {~rsync[ADDR_W:ADDR_W-1], rsync[ADDR_W-2:0]}).
REQ-019 MODE 1 SHALL register flag = (gray_next == rsync).
REQ-020 SHALL hold bin and ptr_gray when inc is asserted while flag = 1, and SHALL set err in the same edge; err clears only on reset.
REQ-021 SHALL wrap the pointer from 2**(ADDR_W+1)-1 to 0 with a single-bit Gray change.
REQ-022 SHALL guarantee that ptr_gray changes by at most one bit per clock.
REQ-023 SHALL deassert flag (remote pointer movement) no earlier than SYNC_STAGES+1 cycles after remote_gray changes.

Reset
REQ-024 SHALL, on n_rst low, asynchronously clear bin, ptr_gray, addr, all rsync flops, err and level to 0.
REQ-025 SHALL reset flag to 0 in MODE 0 and to 1 in MODE 1.
REQ-026 SHALL abort any in-flight increment on reset mid-operation and resume from pointer 0 on the first edge after release.

Configuration
REQ-027 With macro GRAY_PTR_LEVEL_EN defined, SHALL convert rsync to binary rbin and register level = bin_next - rbin (MODE 0) or rbin - bin_next (MODE 1), modulo 2**(ADDR_W+1).
REQ-028 Without GRAY_PTR_LEVEL_EN, SHALL omit the level port and the Gray-to-binary logic entirely.

Structure
REQ-029 SHALL take bin2gray/gray2bin functions and MODE_WR/MODE_RD constants from shared package gray_pkg.
REQ-030 SHALL instantiate the synchroniser as sub-module sync_ff (parameters WIDTH, STAGES, asynchronous active-low reset).

Verification
REQ-031 MODE 0, ADDR_W=2, remote_gray=0: 4 incs -> ptr_gray=3'b110, flag=1 after the 4th edge; 5th inc -> ptr unchanged, err=1.
REQ-032 MODE 1, ADDR_W=2: reset -> flag=1; remote_gray set to 3'b001 -> flag=0 exactly SYNC_STAGES+1 cycles later; one inc -> flag=1 again.
REQ-033 MODE 0, ADDR_W=2, remote tracks local with lag: 8 accepted incs -> ptr_gray returns to 3'b000; check the one-bit-change property every cycle.
REQ-034 Assert n_rst mid-burst at pointer 3 -> all outputs reset immediately (flag per MODE); after release, 1 inc -> ptr_gray=3'b001.
REQ-035 With GRAY_PTR_LEVEL_EN, MODE 0, ADDR_W=2, remote=0: 3 incs -> level=3; remote_gray=3'b011 (binary 2) -> level=1 after SYNC_STAGES+1 cycles.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg -- shared constants and Gray/binary conversion helpers for the
// asynchronous-FIFO pointer controllers.
//
// Contents:
//   MODE_WR / MODE_RD : pointer-side selector (write side -> full flag,
//                       read side -> empty flag)
//   gptr_t            : widest pointer the helpers handle (PTR_MAX_W bits)
//   bin2gray/gray2bin : width-generic conversions. Callers zero-extend into
//                       gptr_t and slice the low bits back out.
package gray_pkg;

  localparam int MODE_WR   = 0;
  localparam int MODE_RD   = 1;
  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] gptr_t;

  function automatic gptr_t bin2gray(input gptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it. The XOR of
  // successively shifted copies builds that prefix parity for every bit at
  // once.
  function automatic gptr_t gray2bin(input gptr_t g);
    gptr_t b;
    b = g;
    for (int i = 1; i < PTR_MAX_W; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_ctl_if.sv
// gray_ptr_ctl_if -- pointer-side bus of one async-FIFO pointer controller.
//
// Signals:
//   inc         : advance request from the FIFO side logic
//   remote_gray : Gray pointer from the opposite clock domain (async)
//   ptr_gray    : registered local Gray pointer, to the opposite domain
//   addr        : registered local binary pointer, low ADDR_W bits (RAM)
//   flag        : full (write side) or empty (read side)
//   err         : sticky overflow/underflow indication
//   level       : occupancy, only with GRAY_PTR_LEVEL_EN defined
//
// Modports: master = FIFO side logic / bench, slave = gray_ptr_ctl.
// Optional feature macro: GRAY_PTR_LEVEL_EN.
interface gray_ptr_ctl_if #(
  parameter int ADDR_W = 4
);
  logic              inc;
  logic [ADDR_W:0]   remote_gray;
  logic [ADDR_W:0]   ptr_gray;
  logic [ADDR_W-1:0] addr;
  logic              flag;
  logic              err;
`ifdef GRAY_PTR_LEVEL_EN
  logic [ADDR_W:0]   level;
`endif

  modport master (
    output inc, remote_gray,
`ifdef GRAY_PTR_LEVEL_EN
    input  level,
`endif
    input  ptr_gray, addr, flag, err
  );

  modport slave (
    input  inc, remote_gray,
`ifdef GRAY_PTR_LEVEL_EN
    output level,
`endif
    output ptr_gray, addr, flag, err
  );

endinterface

// File: rtl/sync_ff.sv
// sync_ff -- multi-flop synchroniser for a Gray-coded bus.
//
// Ports:
//   clk   : destination clock
//   n_rst : asynchronous active-low reset, clears every stage
//   d     : asynchronous input, fed straight into the first flop
//   q     : output of the last stage
//
// Parameters: WIDTH (bus width), STAGES (flop depth, >= 2).
// Only safe for buses that change at most one bit per source clock.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stg <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/gray_ptr_ctl.sv
// gray_ptr_ctl -- one side (write or read) of an asynchronous FIFO pointer
// pair. Keeps a binary pointer plus its Gray image, synchronises the
// opposite side's Gray pointer and derives full/empty from it.
//
// Ports:
//   clk   : local clock, all state on the rising edge
//   n_rst : asynchronous active-low reset
//   bus   : gray_ptr_ctl_if.slave (inc, remote_gray in; ptr_gray, addr,
//           flag, err and optional level out)
//
// Parameters:
//   ADDR_W      : FIFO address width, depth = 2**ADDR_W (>= 2)
//   MODE        : MODE_WR (flag = full) or MODE_RD (flag = empty)
//   SYNC_STAGES : remote-pointer synchroniser depth (>= 2)
//
// Optional feature macro: GRAY_PTR_LEVEL_EN adds the registered occupancy
// output and the Gray-to-binary conversion it needs.
module gray_ptr_ctl
  import gray_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int MODE        = MODE_WR,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  gray_ptr_ctl_if.slave    bus
);

  logic [ADDR_W:0] bin;
  logic [ADDR_W:0] gray_q;
  logic [ADDR_W:0] bin_next;
  logic [ADDR_W:0] gray_next;
  logic [ADDR_W:0] rsync;
  logic [ADDR_W:0] full_cmp;
  logic            flag_q;
  logic            flag_next;
  logic            err_q;
  logic            inc_eff;
  gptr_t           gray_wide;

  // Remote pointer goes into the synchroniser untouched: any logic ahead of
  // the first flop could turn a single-bit Gray change into a multi-bit one.
  sync_ff #(
    .WIDTH  (ADDR_W + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (bus.remote_gray),
    .q     (rsync)
  );

  // A request while the flag is up is dropped, so the pointer can never
  // overrun the opposite side.
  assign inc_eff  = bus.inc & ~flag_q;
  assign bin_next = bin + {{ADDR_W{1'b0}}, inc_eff};

  assign gray_wide = bin2gray(gptr_t'(bin_next));
  assign gray_next = gray_wide[ADDR_W:0];

  // Full: local is exactly one lap ahead of remote. In Gray code that means
  // the top two bits are inverted and the rest are equal.
  assign full_cmp  = {~rsync[ADDR_W:ADDR_W-1], rsync[ADDR_W-2:0]};

  // Flags are computed from the next pointer so they are registered in the
  // same edge that moves the pointer and never lag it by a cycle.
  assign flag_next = (MODE == MODE_WR) ? (gray_next == full_cmp)
                                       : (gray_next == rsync);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bin    <= '0;
      gray_q <= '0;
      flag_q <= (MODE == MODE_RD);  // read side starts empty
      err_q  <= 1'b0;
    end else begin
      bin    <= bin_next;
      gray_q <= gray_next;
      flag_q <= flag_next;
      err_q  <= err_q | (bus.inc & flag_q);
    end
  end

  assign bus.ptr_gray = gray_q;
  assign bus.addr     = bin[ADDR_W-1:0];
  assign bus.flag     = flag_q;
  assign bus.err      = err_q;

`ifdef GRAY_PTR_LEVEL_EN
  gptr_t           rbin_wide;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] level_q;
  logic            unused_hi;

  assign rbin_wide = gray2bin(gptr_t'(rsync));
  assign rbin      = rbin_wide[ADDR_W:0];

  // Modulo-2**(ADDR_W+1) difference; the extra wrap bit keeps a completely
  // full FIFO (difference = depth) distinct from an empty one.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      level_q <= '0;
    else if (MODE == MODE_WR)
      level_q <= bin_next - rbin;
    else
      level_q <= rbin - bin_next;
  end

  assign bus.level = level_q;
  assign unused_hi = ^{gray_wide[PTR_MAX_W-1:ADDR_W+1],
                       rbin_wide[PTR_MAX_W-1:ADDR_W+1]};
`else
  logic unused_hi;
  assign unused_hi = ^gray_wide[PTR_MAX_W-1:ADDR_W+1];
`endif

endmodule

// File: tb/tb_gray_ptr_ctl.sv
// tb_gray_ptr_ctl -- self-checking bench: a write-side (MODE 0) and a
// read-side (MODE 1) controller, both ADDR_W=2, SYNC_STAGES=2. Inputs are
// driven on the falling edge and outputs compared on the next falling edge.
module tb_gray_ptr_ctl;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  gray_ptr_ctl_if #(.ADDR_W(2)) if0 ();
  gray_ptr_ctl_if #(.ADDR_W(2)) if1 ();

  gray_ptr_ctl #(.ADDR_W(2), .MODE(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .n_rst(n_rst), .bus(if0)
  );
  gray_ptr_ctl #(.ADDR_W(2), .MODE(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .n_rst(n_rst), .bus(if1)
  );

  typedef enum int {F_PTR0, F_ADDR0, F_FLAG0, F_ERR0,
                    F_PTR1, F_FLAG1, F_ERR1, F_LVL0} fld_e;
  typedef struct { string name; fld_e fld; int exp; } exp_t;
  typedef struct {
    logic       inc;
    logic [2:0] ptr;
    logic [1:0] addr;
    logic       flag;
    logic       err;
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tab[6];
  logic [2:0] gtab[8];
  logic [2:0] prev;

  function automatic int cur(input fld_e f);
    case (f)
      F_PTR0:  return int'(if0.ptr_gray);
      F_ADDR0: return int'(if0.addr);
      F_FLAG0: return int'(if0.flag);
      F_ERR0:  return int'(if0.err);
      F_PTR1:  return int'(if1.ptr_gray);
      F_FLAG1: return int'(if1.flag);
      F_ERR1:  return int'(if1.err);
`ifdef GRAY_PTR_LEVEL_EN
      F_LVL0:  return int'(if0.level);
`endif
      default: return -1;
    endcase
  endfunction

  task automatic push(input string n, input fld_e f, input int e);
    exp_t x;
    x.name = n; x.fld = f; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_sb();
    exp_t e;
    int   a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = cur(e.fld);
      n_chk++;
      if (a != e.exp) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", e.name, a, e.exp);
      end
    end
  endtask

  // Drive inputs at a falling edge and advance to the next falling edge.
  task automatic step(input logic i0, input logic [2:0] r0,
                      input logic i1, input logic [2:0] r1);
    if0.inc = i0; if0.remote_gray = r0;
    if1.inc = i1; if1.remote_gray = r1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    if0.inc = 1'b0; if0.remote_gray = 3'b000;
    if1.inc = 1'b0; if1.remote_gray = 3'b000;
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic push_reset_vals(input string tag);
    push({tag, "_ptr0"},  F_PTR0,  0);
    push({tag, "_addr0"}, F_ADDR0, 0);
    push({tag, "_flag0"}, F_FLAG0, 0);
    push({tag, "_err0"},  F_ERR0,  0);
    push({tag, "_ptr1"},  F_PTR1,  0);
    push({tag, "_flag1"}, F_FLAG1, 1);
    push({tag, "_err1"},  F_ERR1,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of test");
    $fatal(1, "timeout");
  end

  initial begin
    gtab[0] = 3'b000; gtab[1] = 3'b001; gtab[2] = 3'b011; gtab[3] = 3'b010;
    gtab[4] = 3'b110; gtab[5] = 3'b111; gtab[6] = 3'b101; gtab[7] = 3'b100;

    // write side, remote pointer 0: four incs fill, then overflow attempts
    tab[0] = '{1'b1, 3'b001, 2'd1, 1'b0, 1'b0};
    tab[1] = '{1'b1, 3'b011, 2'd2, 1'b0, 1'b0};
    tab[2] = '{1'b1, 3'b010, 2'd3, 1'b0, 1'b0};
    tab[3] = '{1'b1, 3'b110, 2'd0, 1'b1, 1'b0};
    tab[4] = '{1'b1, 3'b110, 2'd0, 1'b1, 1'b1};
    tab[5] = '{1'b0, 3'b110, 2'd0, 1'b1, 1'b1};

    if0.inc = 1'b0; if0.remote_gray = 3'b000;
    if1.inc = 1'b0; if1.remote_gray = 3'b000;
    repeat (2) @(negedge clk);
    push_reset_vals("rst");
    check_sb();
    n_rst = 1'b1;

    // fill to full and overflow
    for (int k = 0; k < 6; k++) begin
      push($sformatf("fill%0d_ptr", k),  F_PTR0,  int'(tab[k].ptr));
      push($sformatf("fill%0d_addr", k), F_ADDR0, int'(tab[k].addr));
      push($sformatf("fill%0d_flag", k), F_FLAG0, int'(tab[k].flag));
      push($sformatf("fill%0d_err", k),  F_ERR0,  int'(tab[k].err));
      step(tab[k].inc, 3'b000, 1'b0, 3'b000);
      check_sb();
    end

    // reset asserted mid-burst at pointer 3, between clock edges
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      push($sformatf("burst%0d_ptr", k), F_PTR0, int'(gtab[k]));
      step(1'b1, 3'b000, 1'b0, 3'b000);
      check_sb();
    end
    #2 n_rst = 1'b0;
    #1;
    push_reset_vals("midrst");
    check_sb();
    @(negedge clk);
    n_rst = 1'b1;
    push("post_rst_ptr", F_PTR0, 1);
    step(1'b1, 3'b000, 1'b0, 3'b000);
    check_sb();

    // full wrap with a lagging remote: never full, one bit change per cycle
    do_reset();
    prev = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      push($sformatf("wrap%0d_ptr", k),  F_PTR0,  int'(gtab[k % 8]));
      push($sformatf("wrap%0d_flag", k), F_FLAG0, 0);
      step(1'b1, gtab[k-1], 1'b0, 3'b000);
      check_sb();
      n_chk++;
      if ($countones(if0.ptr_gray ^ prev) > 1) begin
        n_fail++;
        $display("FAIL wrap%0d_onebit: got %b after %b, required at most one bit change",
                 k, if0.ptr_gray, prev);
      end
      prev = if0.ptr_gray;
    end

    // read side: empty clears SYNC_STAGES+1 edges after remote moves
    do_reset();
    push("rd_rst_flag", F_FLAG1, 1);
    check_sb();
    push("rd_sync1_flag", F_FLAG1, 1);
    step(1'b0, 3'b000, 1'b0, 3'b001);
    check_sb();
    push("rd_sync2_flag", F_FLAG1, 1);
    step(1'b0, 3'b000, 1'b0, 3'b001);
    check_sb();
    push("rd_sync3_flag", F_FLAG1, 0);
    step(1'b0, 3'b000, 1'b0, 3'b001);
    check_sb();
    push("rd_pop_ptr",  F_PTR1,  1);
    push("rd_pop_flag", F_FLAG1, 1);
    push("rd_pop_err",  F_ERR1,  0);
    step(1'b0, 3'b000, 1'b1, 3'b001);
    check_sb();
    push("rd_under_ptr",  F_PTR1,  1);
    push("rd_under_flag", F_FLAG1, 1);
    push("rd_under_err",  F_ERR1,  1);
    step(1'b0, 3'b000, 1'b1, 3'b001);
    check_sb();

`ifdef GRAY_PTR_LEVEL_EN
    // occupancy: three writes, then the reader advances to binary 2
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      push($sformatf("lvl_wr%0d", k), F_LVL0, k);
      step(1'b1, 3'b000, 1'b0, 3'b000);
      check_sb();
    end
    push("lvl_sync1", F_LVL0, 3);
    step(1'b0, 3'b011, 1'b0, 3'b000);
    check_sb();
    push("lvl_sync2", F_LVL0, 3);
    step(1'b0, 3'b011, 1'b0, 3'b000);
    check_sb();
    push("lvl_sync3", F_LVL0, 1);
    step(1'b0, 3'b011, 1'b0, 3'b000);
    check_sb();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
